// File: rtl/ether_pkg.sv
// Shared Ethernet receive definitions: framer state encoding, RMII sample record
// and preamble/SFD dibit constants.
package ether_pkg;

  typedef enum logic [1:0] {
    DROP,
    IDLE,
    PRE,
    BODY
  } rx_state_e;

  typedef struct packed {
    logic       crsdv;
    logic [1:0] rxd;
  } rmii_smp_t;

  localparam logic [1:0] PREAMBLE_DIBIT  = 2'b01;
  localparam logic [1:0] SFD_LAST_DIBIT  = 2'b11;
  localparam int         DIBITS_PER_BYTE = 4;

endpackage

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, resolves CRS_DV toggling at carrier
// loss and emits frame-body dibits with sof/eof/err markers at a fixed latency.
module rmii_rx_framer
  import ether_pkg::*;
#(
  parameter int MIN_PREAMBLE = 4,
  parameter int MAX_DIBITS   = 6088
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       sof,
  output logic       eof,
  output logic       err
);

  localparam int CW = $clog2(MAX_DIBITS + 1);
  localparam int PW = $clog2(MIN_PREAMBLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_DIBITS - 1);
  localparam logic [PW-1:0] PRE_SAT  = PW'(MIN_PREAMBLE);

  rmii_smp_t     s0, hold;
  rx_state_e     state, state_nx;
  logic [PW-1:0] pre_cnt, pre_cnt_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          emit, sof_nx, trunc_nx, trunc_q;
  logic          is_data, at_end;

  // crsdv resets high so DROP only leaves after two genuine low samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0   <= '{crsdv: 1'b1, rxd: 2'b00};
      hold <= '{crsdv: 1'b1, rxd: 2'b00};
    end else begin
      s0   <= {crsdv, rxd};
      hold <= s0;
    end
  end

  // hold is the dibit under decision, s0 is its successor
  assign is_data = hold.crsdv | s0.crsdv;
  assign at_end  = ~hold.crsdv & ~s0.crsdv;

  always_comb begin
    state_nx   = state;
    pre_cnt_nx = pre_cnt;
    cnt_nx     = cnt;
    emit       = 1'b0;
    trunc_nx   = 1'b0;
    case (state)
      DROP: if (at_end) state_nx = IDLE;
      IDLE: begin
        if (hold.crsdv) begin
          if (hold.rxd == PREAMBLE_DIBIT) begin
            state_nx   = PRE;
            pre_cnt_nx = PW'(1);
          end else if (hold.rxd[1]) begin
            state_nx = DROP;
          end
        end
      end
      PRE: begin
        if (!hold.crsdv) begin
          state_nx = IDLE;
        end else if (hold.rxd == PREAMBLE_DIBIT) begin
          if (pre_cnt != PRE_SAT) pre_cnt_nx = pre_cnt + 1'b1;
        end else if (hold.rxd == SFD_LAST_DIBIT && pre_cnt >= PRE_SAT) begin
          state_nx = BODY;
          cnt_nx   = '0;
        end else begin
          state_nx = DROP;
        end
      end
      BODY: begin
        if (is_data) begin
          emit   = 1'b1;
          cnt_nx = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            trunc_nx = 1'b1;
            state_nx = DROP;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = DROP;
    endcase
    sof_nx = emit && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DROP;
      pre_cnt <= '0;
      cnt     <= '0;
      axiov   <= 1'b0;
      axiod   <= 2'b00;
      sof     <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state   <= state_nx;
      pre_cnt <= pre_cnt_nx;
      cnt     <= cnt_nx;
      axiov   <= emit;
      axiod   <= emit ? hold.rxd : 2'b00;
      sof     <= sof_nx;
      trunc_q <= trunc_nx;
    end
  end

  // End of frame is only known once the two samples after the emitted dibit are in
  assign eof = axiov & (trunc_q | (state == BODY && at_end));
  assign err = eof & (trunc_q | ((cnt % CW'(DIBITS_PER_BYTE)) != '0));

endmodule
